// File: rtl/vms_pkg.sv
// Shared types and default sizing for the vector memory sequencer.
package vms_pkg;
  localparam int unsigned VMS_LANES   = 4;
  localparam int unsigned VMS_DATA_W  = 32;
  localparam int unsigned VMS_ADDR_W  = 32;
  localparam int unsigned VMS_TIMEOUT = 16;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} vms_state_t;
endpackage

// File: rtl/vms_watchdog.sv
// Counts consecutive stalled beats; o_expire fires on the TIMEOUT-th one.
module vms_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stalled,
  output logic o_expire
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_stalled && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !i_stalled || o_expire) r_cnt <= '0;
    else                               r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/vector_mem_sequencer.sv
// Splits a vector load/store into LANES single-word memory beats.
// Optional watchdog enabled by defining VMS_TIMEOUT_EN.
module vector_mem_sequencer
  import vms_pkg::*;
#(
  parameter int unsigned LANES   = VMS_LANES,
  parameter int unsigned DATA_W  = VMS_DATA_W,
  parameter int unsigned ADDR_W  = VMS_ADDR_W,
  parameter int unsigned TIMEOUT = VMS_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_read,
  input  logic                    start_write,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*DATA_W-1:0] wdata_vec,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ready,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic [LANES*DATA_W-1:0] rdata_vec,
  output logic                    vreg_we,
  output logic                    stall,
  output logic                    done,
  output logic                    err
);
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  vms_state_t              r_state, w_next;
  logic [LW-1:0]           r_lane;
  logic [ADDR_W-1:0]       r_base;
  logic [LANES*DATA_W-1:0] r_wdata, r_rdata;
  logic                    r_is_read;
  logic                    w_last, w_timeout;

  assign w_last    = (r_lane == LW'(LANES - 1));
  assign rdata_vec = rst ? '0 : r_rdata;

`ifdef VMS_TIMEOUT_EN
  logic w_stalled;
  assign w_stalled = ((r_state == READ) || (r_state == WRITE)) && !mem_ready;

  vms_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_stalled (w_stalled),
    .o_expire  (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    vreg_we   = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      IDLE: begin
        stall = start_read || start_write;
        err   = start_read && start_write;
        if (start_write)     w_next = WRITE;
        else if (start_read) w_next = READ;
      end
      READ, WRITE: begin
        stall    = 1'b1;
        err      = w_timeout;
        mem_addr = r_base + ADDR_W'(r_lane);
        mem_re   = (r_state == READ);
        mem_we   = (r_state == WRITE);
        if (r_state == WRITE) mem_wdata = r_wdata[int'(r_lane)*DATA_W +: DATA_W];
        if (w_timeout)                w_next = IDLE;
        else if (mem_ready && w_last) w_next = DONE;
      end
      DONE: begin
        done    = 1'b1;
        vreg_we = r_is_read;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Outputs are forced low while reset is held, whatever the current state.
    if (rst) begin
      mem_addr  = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      vreg_we   = 1'b0;
      stall     = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lane    <= '0;
      r_base    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_is_read <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start_read || start_write) begin
            r_base    <= base_addr;
            r_lane    <= '0;
            r_is_read <= !start_write;
          end
          if (start_write) r_wdata <= wdata_vec;
        end
        READ, WRITE: begin
          if (mem_ready) begin
            if (r_state == READ) r_rdata[int'(r_lane)*DATA_W +: DATA_W] <= mem_rdata;
            if (!w_last) r_lane <= r_lane + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed and randomized transfers checked against a transaction-level model.
module tb_vector_mem_sequencer;
  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  logic                    clk = 1'b0;
  logic                    rst, start_read, start_write, mem_ready;
  logic [ADDR_W-1:0]       base_addr;
  logic [LANES*DATA_W-1:0] wdata_vec;
  logic [DATA_W-1:0]       mem_rdata;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_re, mem_we, vreg_we, stall, done, err;
  logic [DATA_W-1:0]       mem_wdata;
  logic [LANES*DATA_W-1:0] rdata_vec;

  int unsigned             ntests = 0;
  int unsigned             nfail  = 0;
  logic [LANES*DATA_W-1:0] model_rdata = '0;
  int unsigned             wait_cfg[LANES];

  always #5 clk = ~clk;

  vector_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start_read(start_read), .start_write(start_write),
    .base_addr(base_addr), .wdata_vec(wdata_vec), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .rdata_vec(rdata_vec), .vreg_we(vreg_we),
    .stall(stall), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".re"},    128'(mem_re),   128'(0));
    check({tag, ".we"},    128'(mem_we),   128'(0));
    check({tag, ".stall"}, 128'(stall),    128'(0));
    check({tag, ".done"},  128'(done),     128'(0));
    check({tag, ".vreg"},  128'(vreg_we),  128'(0));
    check({tag, ".err"},   128'(err),      128'(0));
  endtask

  // One whole transfer; wait_cfg[k] gives the not-ready cycles before beat k completes.
  task automatic run_op(input bit rd, input bit wr, input logic [31:0] base,
                        input logic [127:0] wvec, input bit patterned);
    bit          is_read;
    logic [31:0] addr, d;
    is_read = rd && !wr;
    @(negedge clk);
    start_read = rd; start_write = wr; base_addr = base; wdata_vec = wvec;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    #1;
    check("start.err",   128'(err),   128'(rd && wr));
    check("start.stall", 128'(stall), 128'(1));
    @(posedge clk); #1;
    base_addr = $urandom; wdata_vec = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < int'(LANES); k++) begin
      addr = base + 32'(k);
      d = patterned ? addr + 32'hA0 : $urandom;
      for (int w = 0; w <= int'(wait_cfg[k]); w++) begin
        @(negedge clk);
        mem_ready   = (w == int'(wait_cfg[k]));
        mem_rdata   = mem_ready ? d : $urandom;
        start_read  = 1'($urandom);
        start_write = 1'($urandom);
        #1;
        check("beat.addr",  128'(mem_addr), 128'(addr));
        check("beat.re",    128'(mem_re),   128'(is_read));
        check("beat.we",    128'(mem_we),   128'(!is_read));
        if (!is_read) check("beat.wdata", 128'(mem_wdata), 128'(wvec[k*32 +: 32]));
        check("beat.stall", 128'(stall),    128'(1));
        check("beat.done",  128'(done),     128'(0));
        check("beat.err",   128'(err),      128'(0));
        check("beat.rdata", rdata_vec,      model_rdata);
        @(posedge clk);
        if (mem_ready && is_read) model_rdata[k*32 +: 32] = d;
      end
    end
    @(negedge clk);
    start_read = 1'b0; start_write = 1'b0; mem_ready = 1'($urandom);
    #1;
    check("done.done",  128'(done),    128'(1));
    check("done.vreg",  128'(vreg_we), 128'(is_read));
    check("done.stall", 128'(stall),   128'(0));
    check("done.re",    128'(mem_re),  128'(0));
    check("done.we",    128'(mem_we),  128'(0));
    check("done.err",   128'(err),     128'(0));
    check("done.rdata", rdata_vec,     model_rdata);
  endtask

  initial begin
    rst = 1'b1; start_read = 1'b0; start_write = 1'b0; mem_ready = 1'b0;
    base_addr = '0; wdata_vec = '0; mem_rdata = '0;
    foreach (wait_cfg[i]) wait_cfg[i] = 0;
    @(negedge clk); #1;
    check_quiet("rst");
    check("rst.addr",  128'(mem_addr), 128'(0));
    check("rst.rdata", rdata_vec,      128'(0));
    @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check_quiet("post_rst");

    // Load at 0x100 with data = addr + 0xA0
    run_op(1'b1, 1'b0, 32'h100, '0, 1'b1);
    check("load.lanes", rdata_vec, 128'h000001A3_000001A2_000001A1_000001A0);
    // Store 0x11..0x44 at 0x20; rdata must hold the previous load
    run_op(1'b0, 1'b1, 32'h20, 128'h00000044_00000033_00000022_00000011, 1'b0);
    // Backpressure on lane 2
    wait_cfg[2] = 3;
    run_op(1'b1, 1'b0, 32'h100, '0, 1'b1);
    wait_cfg[2] = 0;
    // Address wrap and read/write conflict
    run_op(1'b1, 1'b0, 32'hFFFFFFFE, '0, 1'b0);
    run_op(1'b1, 1'b1, 32'h40, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

    // Reset during lane 1 of a load
    @(negedge clk); start_read = 1'b1; base_addr = 32'h300; mem_ready = 1'b1;
    @(posedge clk); #1; start_read = 1'b0;
    @(negedge clk); mem_ready = 1'b1; mem_rdata = $urandom;
    @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    check_quiet("midrst");
    check("midrst.addr",  128'(mem_addr), 128'(0));
    check("midrst.rdata", rdata_vec,      128'(0));
    @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    model_rdata = '0;
    check_quiet("midrst.after");
    check("midrst.after_rdata", rdata_vec, model_rdata);
    @(negedge clk); #1;
    check_quiet("midrst.idle");

    // Randomized transfers with random backpressure
    for (int n = 0; n < 24; n++) begin
      int unsigned op;
      op = $urandom_range(0, 2);
      foreach (wait_cfg[i]) wait_cfg[i] = $urandom_range(0, 3);
      run_op(op != 1, op != 0, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end
    foreach (wait_cfg[i]) wait_cfg[i] = 0;

`ifdef VMS_TIMEOUT_EN
    @(negedge clk); start_read = 1'b1; base_addr = $urandom; mem_ready = 1'b0;
    @(posedge clk); #1; start_read = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk); #1;
      check("wd.re",  128'(mem_re), 128'(1));
      check("wd.err", 128'(err),    128'(c == 16));
      @(posedge clk);
    end
    @(negedge clk); #1;
    check_quiet("wd.after");
    check("wd.rdata", rdata_vec, model_rdata);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/vector_mem_sequencer.md
VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 The block SHALL expose the following parameters:
- LANES, default 4, number of vector elements per transfer.
- DATA_W, default 32, element width in bits.
- ADDR_W, default 32, word address width.
- TIMEOUT, default 16, watchdog limit in cycles.
REQ-002 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-003 The block SHALL have the following ports, in this order (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  sync active-high reset.
- start_read  in  1  vector load request, from EnableRead.
- start_write  in  1  vector store request, from EnableWrite.
- base_addr  in  ADDR_W  element-0 word address.
- wdata_vec  in  LANES*DATA_W  store data; lane i occupies bits [i*DATA_W +: DATA_W].
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory accepts the current beat.
- mem_addr  out  ADDR_W  beat address.
- mem_re  out  1  read strobe.
- mem_we  out  1  write strobe.
- mem_wdata  out  DATA_W  beat write data.
- rdata_vec  out  LANES*DATA_W  assembled load data.
- vreg_we  out  1  vector register write enable.
- stall  out  1  pipeline hold.
- done  out  1  completion pulse.
- err  out  1  error pulse.

Function
REQ-004 The state machine SHALL have four states, IDLE, READ, WRITE and DONE, plus a lane counter of width clog2(LANES).
REQ-005 In IDLE with start_write=1, the block SHALL latch base_addr and wdata_vec, clear the lane counter and go to WRITE.
REQ-006 In IDLE with start_read=1 only, the block SHALL latch base_addr, clear the lane counter and go to READ.
REQ-007 If start_read and start_write are both 1 in IDLE, write SHALL win and err SHALL pulse for one cycle in that same cycle.
REQ-008 In READ and WRITE, mem_addr SHALL equal latched base plus lane, modulo 2^ADDR_W (wraps silently).
REQ-009 In READ, mem_re SHALL be 1; on mem_ready=1, mem_rdata SHALL be stored into rdata_vec lane slot.
REQ-010 In WRITE, mem_we SHALL be 1 and mem_wdata SHALL carry the latched lane slot; a beat completes on mem_ready=1.
REQ-011 While mem_ready=0, the block SHALL hold address, strobes and lane unchanged.
REQ-012 On a completed beat with lane==LANES-1, the block SHALL go to DONE; otherwise it SHALL increment lane.
REQ-013 DONE SHALL last exactly one cycle: done=1, vreg_we=1 only if the operation was a read, then return to IDLE.
REQ-014 stall SHALL be 1 when in IDLE with any start asserted, and throughout READ and WRITE; stall SHALL be 0 in DONE and otherwise.
REQ-015 Start inputs SHALL be ignored outside IDLE.
REQ-016 With mem_ready tied to 1, done SHALL assert exactly LANES+1 cycles after the start edge.
REQ-017 rdata_vec SHALL hold its value until the next read completes a beat.

Reset
REQ-018 On rst=1 at a clock edge, including mid-transfer, the block SHALL enter IDLE with lane=0.
REQ-019 Reset SHALL clear rdata_vec and all latches to 0.
REQ-020 During reset every output SHALL be 0, and no memory strobe SHALL issue in the cycle following reset.

Configuration
REQ-021 With VMS_TIMEOUT_EN defined, a watchdog SHALL count consecutive cycles with a strobe asserted and mem_ready=0.
REQ-022 With VMS_TIMEOUT_EN defined, if the count reaches TIMEOUT the block SHALL pulse err, return to IDLE without done or vreg_we, and leave rdata_vec partially updated.
REQ-023 Without VMS_TIMEOUT_EN, no watchdog logic SHALL exist and the block SHALL wait for mem_ready indefinitely.

Structure
REQ-024 Shared package vms_pkg SHALL hold the state enum (IDLE, READ, WRITE, DONE) and the default LANES, DATA_W, ADDR_W and TIMEOUT constants.
REQ-025 The watchdog SHALL be sub-module vms_watchdog, instantiated only under VMS_TIMEOUT_EN; all other logic stays in one module.

Verification
REQ-026 Load: base_addr=0x100, mem_ready=1, mem_rdata=addr+0xA0 -> addresses 0x100..0x103; rdata_vec lanes 0x1A0..0x1A3; done and vreg_we pulse at cycle 5.
REQ-027 Store: wdata_vec lanes 0x11,0x22,0x33,0x44, base_addr=0x20 -> mem_we with those values at 0x20..0x23; done at cycle 5, vreg_we=0.
REQ-028 Backpressure: mem_ready low 3 cycles on lane 2 -> address 0x102 held for 4 cycles, stall stays 1, done at cycle 8.
REQ-029 Wrap and conflict:
- base_addr=0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
- start_read=start_write=1 -> write sequence runs and err pulses in the start cycle.
REQ-030 Reset and timeout:
- rst asserted during lane 1 -> IDLE next cycle, all outputs 0, no done.
- With VMS_TIMEOUT_EN and mem_ready=0 -> err after 16 cycles, then IDLE.
